fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain. It synchronises the Gray write pointer from the write domain and owns the binary and Gray read pointers. It addresses the FIFO memory's combinational read port and presents words through a registered first-word-fall-through valid/ready output stage. Its Gray read pointer is exported back to the write domain for full detection.

---
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for an asynchronous FIFO.
// Lives in the rclk domain. It synchronises the Gray write pointer, owns
// the binary and Gray read pointers, and presents memory words through a
// registered first-word-fall-through valid/ready stage.
// Optional macro FIFO_RD_LEVEL_EN adds the rd_level occupancy output.

module fifo_rd_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    g_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  out_ready,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  mem_empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_WIDTH+1:0]  rd_level
`endif
);

  // The pointer arithmetic relies on the memory being a power of two deep.
  if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must equal 2**PTR_WIDTH");
  end

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0]    r_wptr_s1;
  logic [PTR_WIDTH:0]    r_wptr_sync;
  logic [PTR_WIDTH:0]    r_b_rptr;
  logic [PTR_WIDTH:0]    r_g_rptr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic                  w_mem_empty;
  logic                  w_load;
  logic                  w_unload;
  logic [PTR_WIDTH:0]    w_b_rptr_next;
  logic [PTR_WIDTH:0]    w_g_rptr_next;

  // Two-flop synchroniser for the Gray write pointer; nothing sits between
  // the stages so only one bit can be in flight at a time.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_wptr_s1   <= '0;
      r_wptr_sync <= '0;
    end else begin
      r_wptr_s1   <= g_wptr;
      r_wptr_sync <= r_wptr_s1;
    end
  end

  // Empty when the registered Gray read pointer catches the synchronised
  // write pointer; comparing all bits including the wrap bit.
  assign w_mem_empty   = (r_g_rptr == r_wptr_sync);
  assign w_load        = (!r_out_valid || out_ready) && !w_mem_empty;
  assign w_unload      = r_out_valid && out_ready;
  assign w_b_rptr_next = r_b_rptr + PTR_ONE;
  assign w_g_rptr_next = w_b_rptr_next ^ (w_b_rptr_next >> 1);

  // Read pointers and output stage: load a new word whenever the output slot
  // is free or being drained, otherwise drop valid on accept, otherwise hold.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_b_rptr    <= '0;
      r_g_rptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= mem_rdata;
      r_out_valid <= 1'b1;
      r_b_rptr    <= w_b_rptr_next;
      r_g_rptr    <= w_g_rptr_next;
    end else if (w_unload) begin
      r_out_valid <= 1'b0;
    end
  end

  assign b_rptr    = r_b_rptr;
  assign g_rptr    = r_g_rptr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign mem_empty = w_mem_empty;

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_WIDTH:0] w_wptr_bin;
  logic [PTR_WIDTH:0] w_diff;

  // Gray-to-binary of the synchronised write pointer (XOR prefix from MSB),
  // then words in memory plus the one held in the output register.
  // NOTE: every always_comb output gets a value before any conditional logic
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_wptr_bin            = '0;
    w_wptr_bin[PTR_WIDTH] = r_wptr_sync[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      w_wptr_bin[i] = w_wptr_bin[i+1] ^ r_wptr_sync[i];
    end
  end

  assign w_diff   = w_wptr_bin - r_b_rptr;
  assign rd_level = {1'b0, w_diff} + {{(PTR_WIDTH+1){1'b0}}, r_out_valid};
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed self-checking bench for fifo_rd_ctrl
// (DEPTH=8, PTR_WIDTH=3). The memory is a fixed function of the read address.

module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [PW:0]   g_wptr;
  logic [DW-1:0] mem_rdata;
  logic          out_ready;
  logic [PW:0]   b_rptr;
  logic [PW:0]   g_rptr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          mem_empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW+1:0] rd_level;
`endif

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.DEPTH(8), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .g_wptr    (g_wptr),
    .mem_rdata (mem_rdata),
    .out_ready (out_ready),
    .b_rptr    (b_rptr),
    .g_rptr    (g_rptr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .mem_empty (mem_empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  always #5 rclk = ~rclk;

  function automatic logic [DW-1:0] data_at(input logic [PW-1:0] a);
    logic [DW-1:0] hi;
    hi = {1'b0, a, 4'h0};
    return 8'hA5 + hi;
  endfunction

  function automatic logic [PW:0] gray(input logic [PW:0] v);
    return v ^ (v >> 1);
  endfunction

  // Combinational memory read port modelled from the read address.
  always_comb mem_rdata = data_at(b_rptr[PW-1:0]);

  // Gray read pointer must change by exactly one bit per step.
  logic [PW:0] prev_g = '0;
  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_g = '0;
    end else if (g_rptr !== prev_g) begin
      checks++;
      assert ($countones(g_rptr ^ prev_g) == 1)
      else begin
        $display("FAIL gray_one_bit: g_rptr %b -> %b", prev_g, g_rptr);
        errors++;
      end
      prev_g = g_rptr;
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      errors++;
    end
  endtask

  task automatic do_reset();
    rrst_n    = 1'b0;
    g_wptr    = '0;
    out_ready = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rrst_n    = 1'b0;
    g_wptr    = 4'b0101;
    out_ready = 1'b0;
    step();
    step();
    expect_val("rst_b_rptr", 32'(b_rptr), 32'h0);
    expect_val("rst_g_rptr", 32'(g_rptr), 32'h0);
    expect_val("rst_out_valid", 32'(out_valid), 32'h0);
    expect_val("rst_out_data", 32'(out_data), 32'h0);
    expect_val("rst_mem_empty", 32'(mem_empty), 32'h1);
    g_wptr = 4'b0000;
    rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_val("rst_idle_valid", 32'(out_valid), 32'h0);
    end
  endtask

  task automatic test_first_word();
    do_reset();
    out_ready = 1'b1;
    g_wptr    = 4'b0001;
    step();
    expect_val("lat_n_valid", 32'(out_valid), 32'h0);
    step();
    expect_val("lat_n1_valid", 32'(out_valid), 32'h0);
    expect_val("lat_n1_empty", 32'(mem_empty), 32'h0);
    step();
    expect_val("lat_n2_valid", 32'(out_valid), 32'h1);
    expect_val("lat_n2_data", 32'(out_data), 32'hA5);
    expect_val("lat_n2_b_rptr", 32'(b_rptr), 32'h1);
    expect_val("lat_n2_g_rptr", 32'(g_rptr), 32'h1);
    expect_val("lat_n2_empty", 32'(mem_empty), 32'h1);
    step();
    expect_val("lat_drain_valid", 32'(out_valid), 32'h0);
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    g_wptr    = 4'b0010;
    step();
    step();
    step();
    expect_val("bp_valid", 32'(out_valid), 32'h1);
    expect_val("bp_data", 32'(out_data), 32'hA5);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_val("bp_hold_data", 32'(out_data), 32'hA5);
      expect_val("bp_hold_b_rptr", 32'(b_rptr), 32'h1);
      expect_val("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    step();
    expect_val("bp_w1_data", 32'(out_data), 32'hB5);
    expect_val("bp_w1_b_rptr", 32'(b_rptr), 32'h2);
    expect_val("bp_w1_valid", 32'(out_valid), 32'h1);
    step();
    expect_val("bp_w2_data", 32'(out_data), 32'hC5);
    expect_val("bp_w2_b_rptr", 32'(b_rptr), 32'h3);
    expect_val("bp_w2_empty", 32'(mem_empty), 32'h1);
    step();
    expect_val("bp_end_valid", 32'(out_valid), 32'h0);
    expect_val("bp_end_b_rptr", 32'(b_rptr), 32'h3);
    expect_val("bp_end_data", 32'(out_data), 32'hC5);
  endtask

  task automatic test_wrap();
    logic [PW:0] prev_b;
    logic [PW:0] wp4;
    int          wp;
    int          n_words;
    bit          seen_wrap;
    do_reset();
    out_ready = 1'b1;
    wp        = 0;
    n_words   = 0;
    prev_b    = '0;
    seen_wrap = 1'b0;
    for (int cyc = 0; cyc < 80 && n_words < 20; cyc++) begin
      if (wp < 20) wp++;
      wp4    = 4'(wp);
      g_wptr = gray(wp4);
      step();
      if (b_rptr !== prev_b) begin
        expect_val("wrap_b_incr", 32'(b_rptr), 32'(4'(prev_b + 4'd1)));
        expect_val("wrap_g_rptr", 32'(g_rptr), 32'(gray(4'(prev_b + 4'd1))));
        if (prev_b == 4'd15) begin
          seen_wrap = 1'b1;
          expect_val("wrap_g_zero", 32'(g_rptr), 32'h0);
        end
        prev_b = b_rptr;
      end
      if (out_valid) begin
        expect_val("wrap_data", 32'(out_data), 32'(data_at(3'(n_words))));
        n_words++;
      end
    end
    expect_val("wrap_word_count", 32'(n_words), 32'd20);
    expect_val("wrap_seen", 32'(seen_wrap), 32'h1);
    expect_val("wrap_final_b", 32'(b_rptr), 32'h4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    g_wptr    = 4'b0100;
    step();
    step();
    step();
    expect_val("rm_pre_valid", 32'(out_valid), 32'h1);
    rrst_n = 1'b0;
    g_wptr = 4'b0000;
    #1;
    expect_val("rm_async_valid", 32'(out_valid), 32'h0);
    expect_val("rm_async_b", 32'(b_rptr), 32'h0);
    expect_val("rm_async_g", 32'(g_rptr), 32'h0);
    expect_val("rm_async_data", 32'(out_data), 32'h0);
    step();
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_val("rm_post_valid", 32'(out_valid), 32'h0);
      expect_val("rm_post_b", 32'(b_rptr), 32'h0);
    end
  endtask

`ifdef FIFO_RD_LEVEL_EN
  task automatic test_level();
    do_reset();
    expect_val("lvl_reset", 32'(rd_level), 32'h0);
    out_ready = 1'b0;
    g_wptr    = 4'b0101;
    step();
    expect_val("lvl_s1", 32'(rd_level), 32'h0);
    step();
    expect_val("lvl_sync", 32'(rd_level), 32'h6);
    step();
    expect_val("lvl_b_rptr", 32'(b_rptr), 32'h1);
    expect_val("lvl_valid", 32'(out_valid), 32'h1);
    expect_val("lvl_stalled", 32'(rd_level), 32'h6);
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef FIFO_RD_LEVEL_EN
    test_level();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
